// File: rtl/keypad_scan_fsm.sv
// Keypad row scanner with press/release debounce, hex decode and 2-deep history.
// Optional: define KEYPAD_REPEAT_EN to re-accept a held key every REPEAT_CYCLES.
module keypad_scan_fsm #(
    parameter int DEBOUNCE_CYCLES = 48,
    parameter int SYNC_LAT        = 2
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int REPEAT_CYCLES   = 1200
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic [3:0] new_value,
    output logic [3:0] old_value,
    output logic       key_valid
);

    localparam int DW = (SYNC_LAT > 0) ? $clog2(SYNC_LAT + 1) : 1;
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SYNC_LAT);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN,
        DEB_PRESS,
        HELD,
        DEB_RELEASE
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      row_idx_q, row_idx_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [CW-1:0]   deb_q, deb_d;
    logic [1:0]      col_q, col_d;
    logic [3:0]      rows_q, rows_d;
    logic [3:0]      new_value_q, new_value_d;
    logic [3:0]      old_value_q, old_value_d;
    logic            key_valid_q, key_valid_d;

    logic            sample;
    logic            advance;
    logic            accept;
    logic            rearm;
    logic [2:0]      hit;
    logic [3:0]      cap_pattern;
    logic            cap_high;

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0]   rep_q, rep_d;
`endif

    // {valid, column index}; valid only when exactly one column is low
    function automatic logic [2:0] one_cold(input logic [3:0] c);
        logic [2:0] r;
        r = 3'b000;
        unique case (c)
            4'b1110: r = 3'b100;
            4'b1101: r = 3'b101;
            4'b1011: r = 3'b110;
            4'b0111: r = 3'b111;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] key_lut(
        input logic [1:0] r,
        input logic [1:0] c
    );
        logic [3:0] v;
        v = 4'h0;
        unique case ({r, c})
            4'h0: v = 4'h1;
            4'h1: v = 4'h2;
            4'h2: v = 4'h3;
            4'h3: v = 4'hA;
            4'h4: v = 4'h4;
            4'h5: v = 4'h5;
            4'h6: v = 4'h6;
            4'h7: v = 4'hB;
            4'h8: v = 4'h7;
            4'h9: v = 4'h8;
            4'hA: v = 4'h9;
            4'hB: v = 4'hC;
            4'hC: v = 4'hE;
            4'hD: v = 4'h0;
            4'hE: v = 4'hF;
            4'hF: v = 4'hD;
        endcase
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= SCAN;
            row_idx_q   <= '0;
            dwell_q     <= '0;
            deb_q       <= '0;
            col_q       <= '0;
            rows_q      <= 4'b1110;
            new_value_q <= '0;
            old_value_q <= '0;
            key_valid_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            dwell_q     <= dwell_d;
            deb_q       <= deb_d;
            col_q       <= col_d;
            rows_q      <= rows_d;
            new_value_q <= new_value_d;
            old_value_q <= old_value_d;
            key_valid_q <= key_valid_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= rep_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        row_idx_d   = row_idx_q;
        dwell_d     = dwell_q;
        deb_d       = deb_q;
        col_d       = col_q;
        advance     = 1'b0;
        accept      = 1'b0;
        rearm       = 1'b0;
        sample      = (dwell_q == DWELL_LAST);
        hit         = one_cold(cols);
        cap_pattern = ~(4'b0001 << col_q);
        cap_high    = cols[col_q];

        unique case (state_q)
            SCAN: begin
                if (!sample) begin
                    dwell_d = dwell_q + 1'b1;
                end else if (hit[2]) begin
                    state_d = DEB_PRESS;
                    col_d   = hit[1:0];
                    deb_d   = '0;
                end else begin
                    advance = 1'b1;
                end
            end
            DEB_PRESS: begin
                if (cols != cap_pattern) begin
                    state_d = SCAN;
                    advance = 1'b1;
                end else if (deb_q == DEB_LAST) begin
                    state_d = HELD;
                    accept  = 1'b1;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            HELD: begin
                if (cap_high) begin
                    state_d = DEB_RELEASE;
                    deb_d   = '0;
                end
            end
            DEB_RELEASE: begin
                if (!cap_high) begin
                    deb_d = '0;
                end else if (deb_q == DEB_LAST) begin
                    state_d = SCAN;
                    advance = 1'b1;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
        endcase

        if (advance) begin
            row_idx_d = row_idx_q + 2'd1;
            dwell_d   = '0;
        end

`ifdef KEYPAD_REPEAT_EN
        // Counter only runs while staying in HELD, so entry and exit clear it
        rep_d = '0;
        if (state_q == HELD && state_d == HELD) begin
            if (rep_q == REP_LAST) begin
                rearm = 1'b1;
            end else begin
                rep_d = rep_q + 1'b1;
            end
        end
`endif
    end

    always_comb begin
        rows_d      = ~(4'b0001 << row_idx_d);
        new_value_d = new_value_q;
        old_value_d = old_value_q;
        key_valid_d = 1'b0;
        if (accept) begin
            old_value_d = new_value_q;
            new_value_d = key_lut(row_idx_q, col_q);
            key_valid_d = 1'b1;
        end else if (rearm) begin
            old_value_d = new_value_q;
            key_valid_d = 1'b1;
        end
    end

    assign rows      = rows_q;
    assign new_value = new_value_q;
    assign old_value = old_value_q;
    assign key_valid = key_valid_q;

endmodule
